// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin arbiter and 16/32-bit access sequencer for the data memory port
module dmem_arbiter #(
    parameter int WORD_LENGTH   = 16,
    parameter int ADDRESS_SPACE = 12
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       req_0,
    input  logic [ADDRESS_SPACE-1:0]   addr_0,
    input  logic [2*WORD_LENGTH-1:0]   wdata_0,
    input  logic                       we_0,
    input  logic                       dw_0,
    output logic                       done_0,
    input  logic                       req_1,
    input  logic [ADDRESS_SPACE-1:0]   addr_1,
    input  logic [2*WORD_LENGTH-1:0]   wdata_1,
    input  logic                       we_1,
    input  logic                       dw_1,
    output logic                       done_1,
    output logic [2*WORD_LENGTH-1:0]   rdata,
    output logic [ADDRESS_SPACE-1:0]   MAR,
    output logic [WORD_LENGTH-1:0]     MDR_in,
    output logic                       mem,
    output logic                       rw,
    input  logic [WORD_LENGTH-1:0]     MDR_out,
    output logic                       busy
);

    localparam int DW = 2 * WORD_LENGTH;

    typedef enum logic [1:0] {IDLE, ACC0, ACC1, FIN} state_t;

    state_t                     state;
    logic                       grant;
    logic                       last_grant;
    logic [ADDRESS_SPACE-1:0]   addr_q;
    logic [WORD_LENGTH-1:0]     wdata_hi_q;
    logic                       we_q;
    logic                       dw_q;
    logic [WORD_LENGTH-1:0]     lo_q;

    logic                       pick;
    logic [ADDRESS_SPACE-1:0]   sel_addr;
    logic [DW-1:0]              sel_wdata;
    logic                       sel_we;
    logic                       sel_dw;
    logic [DW-1:0]              rdata_fin;

    // On a tie the requester not served last time wins; otherwise whoever is asking.
    always_comb begin
        pick      = (req_0 && req_1) ? ~last_grant : req_1;
        sel_addr  = pick ? addr_1  : addr_0;
        sel_wdata = pick ? wdata_1 : wdata_0;
        sel_we    = pick ? we_1    : we_0;
        sel_dw    = pick ? dw_1    : dw_0;
        rdata_fin = dw_q ? {MDR_out, lo_q} : {{WORD_LENGTH{1'b0}}, MDR_out};
    end

    // The final word arrives from memory during FIN itself, so it is passed straight through.
    assign rdata = (state == FIN && !we_q) ? rdata_fin : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            addr_q     <= '0;
            wdata_hi_q <= '0;
            we_q       <= 1'b0;
            dw_q       <= 1'b0;
            lo_q       <= '0;
            MAR        <= '0;
            MDR_in     <= '0;
            mem        <= 1'b0;
            rw         <= 1'b1;
            done_0     <= 1'b0;
            done_1     <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_0 || req_1) begin
                        grant      <= pick;
                        addr_q     <= sel_addr;
                        wdata_hi_q <= sel_wdata[DW-1:WORD_LENGTH];
                        we_q       <= sel_we;
                        dw_q       <= sel_dw;
                        state      <= ACC0;
                        busy       <= 1'b1;
                        mem        <= 1'b1;
                        MAR        <= sel_addr;
                        rw         <= ~sel_we;
                        MDR_in     <= sel_wdata[WORD_LENGTH-1:0];
                    end
                end
                ACC0: begin
                    if (dw_q) begin
                        state  <= ACC1;
                        MAR    <= addr_q + ADDRESS_SPACE'(1);
                        MDR_in <= wdata_hi_q;
                    end else begin
                        state  <= FIN;
                        mem    <= 1'b0;
                        MAR    <= '0;
                        MDR_in <= '0;
                        rw     <= 1'b1;
                        done_0 <= ~grant;
                        done_1 <= grant;
                    end
                end
                ACC1: begin
                    if (!we_q) begin
                        lo_q <= MDR_out;
                    end
                    state  <= FIN;
                    mem    <= 1'b0;
                    MAR    <= '0;
                    MDR_in <= '0;
                    rw     <= 1'b1;
                    done_0 <= ~grant;
                    done_1 <= grant;
                end
                default: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    done_0     <= 1'b0;
                    done_1     <= 1'b0;
                    last_grant <= grant;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - randomized self-checking bench for dmem_arbiter against a word-memory reference model
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_0 = 1'b0, req_1 = 1'b0;
    logic [11:0] addr_0 = '0, addr_1 = '0;
    logic [31:0] wdata_0 = '0, wdata_1 = '0;
    logic        we_0 = 1'b0, we_1 = 1'b0, dw_0 = 1'b0, dw_1 = 1'b0;
    logic        done_0, done_1;
    logic [31:0] rdata;
    logic [11:0] MAR;
    logic [15:0] MDR_in;
    logic        mem, rw, busy;
    logic [15:0] MDR_out = '0;

    int errors = 0;
    int checks = 0;

    logic [15:0] mem_arr [0:4095];
    logic [15:0] ref_mem [0:4095];
    int          grant_q[$];
    logic [11:0] mar_q[$];
    logic [15:0] mdr_q[$];
    int          mem_cnt = 0;

    dmem_arbiter #(.WORD_LENGTH(16), .ADDRESS_SPACE(12)) dut (
        .clk(clk), .reset(reset),
        .req_0(req_0), .addr_0(addr_0), .wdata_0(wdata_0), .we_0(we_0), .dw_0(dw_0), .done_0(done_0),
        .req_1(req_1), .addr_1(addr_1), .wdata_1(wdata_1), .we_1(we_1), .dw_1(dw_1), .done_1(done_1),
        .rdata(rdata), .MAR(MAR), .MDR_in(MDR_in), .mem(mem), .rw(rw), .MDR_out(MDR_out), .busy(busy)
    );

    always #5 clk = ~clk;

    // Synchronous memory device: writes land at the edge, reads appear the following cycle.
    always @(posedge clk) begin
        if (mem) begin
            if (!rw) mem_arr[MAR] <= MDR_in;
            else     MDR_out <= mem_arr[MAR];
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            checks++;
            if ((done_0 && done_1) || (mem && (!busy || done_0 || done_1))) begin
                errors++;
                $display("FAIL invariant: done_0=%b done_1=%b mem=%b busy=%b", done_0, done_1, mem, busy);
            end
            if (done_0) grant_q.push_back(0);
            if (done_1) grant_q.push_back(1);
            if (mem) begin
                mem_cnt++;
                mar_q.push_back(MAR);
                mdr_q.push_back(MDR_in);
            end
        end
    end

    function automatic logic [31:0] model_read(input logic [11:0] a, input logic dw);
        return dw ? {ref_mem[a + 12'd1], ref_mem[a]} : {16'h0000, ref_mem[a]};
    endfunction

    task automatic model_write(input logic [11:0] a, input logic [31:0] wd, input logic dw);
        ref_mem[a] = wd[15:0];
        if (dw) ref_mem[a + 12'd1] = wd[31:16];
    endtask

    task automatic set_req(input int r, input logic v);
        if (r == 0) req_0 = v;
        else        req_1 = v;
    endtask

    // Starts at a negedge, returns at the negedge of the done cycle with req already dropped.
    task automatic do_txn(input int r, input logic [11:0] a, input logic [31:0] wd, input logic we,
                          input logic dw, output int lat, output logic [31:0] rd);
        logic got;
        got = 1'b0;
        lat = 0;
        rd  = '0;
        if (r == 0) begin addr_0 = a; wdata_0 = wd; we_0 = we; dw_0 = dw; end
        else        begin addr_1 = a; wdata_1 = wd; we_1 = we; dw_1 = dw; end
        set_req(r, 1'b1);
        while (!got && lat < 30) begin
            @(negedge clk);
            lat++;
            got = (r == 0) ? done_0 : done_1;
        end
        rd = rdata;
        set_req(r, 1'b0);
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL timeout: requester %0d got no done within %0d cycles", r, lat);
            lat = -1;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({done_0, done_1, busy, mem, rw} !== 5'b00001) begin
            errors++;
            $display("FAIL reset_ctl: done_0,done_1,busy,mem,rw=%b required 00001", {done_0, done_1, busy, mem, rw});
        end
        checks++;
        if (MAR !== 12'h000 || MDR_in !== 16'h0000 || rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: MAR=%h MDR_in=%h rdata=%h required zeros", MAR, MDR_in, rdata);
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        int lat, c0;
        logic [31:0] rd;
        c0 = mem_cnt;
        do_txn(0, 12'd10, 32'h0000_0064, 1'b1, 1'b0, lat, rd);
        model_write(12'd10, 32'h0000_0064, 1'b0);
        checks++;
        if (lat !== 2 || mem_cnt - c0 !== 1) begin
            errors++;
            $display("FAIL single_write: latency=%0d mem_cycles=%0d required 2 and 1", lat, mem_cnt - c0);
        end
        @(negedge clk);
        c0 = mem_cnt;
        do_txn(0, 12'd10, 32'h0, 1'b0, 1'b0, lat, rd);
        checks++;
        if (lat !== 2 || mem_cnt - c0 !== 1) begin
            errors++;
            $display("FAIL single_read_timing: latency=%0d mem_cycles=%0d required 2 and 1", lat, mem_cnt - c0);
        end
        checks++;
        if (rd !== 32'h0000_0064) begin
            errors++;
            $display("FAIL single_read_data: rdata=%h required 00000064", rd);
        end
        @(negedge clk);
    endtask

    task automatic test_wrap();
        int lat;
        logic [31:0] rd;
        mar_q.delete();
        mdr_q.delete();
        do_txn(1, 12'hFFF, 32'hABCD_1234, 1'b1, 1'b1, lat, rd);
        model_write(12'hFFF, 32'hABCD_1234, 1'b1);
        checks++;
        if (lat !== 3 || mar_q.size() != 2 || mar_q[0] !== 12'hFFF || mar_q[1] !== 12'h000) begin
            errors++;
            $display("FAIL wrap_write_addr: latency=%0d MAR count=%0d required 3, FFF then 000", lat, mar_q.size());
        end
        checks++;
        if (mdr_q.size() != 2 || mdr_q[0] !== 16'h1234 || mdr_q[1] !== 16'hABCD) begin
            errors++;
            $display("FAIL wrap_write_data: MDR_in count=%0d required 1234 then ABCD", mdr_q.size());
        end
        @(negedge clk);
        mar_q.delete();
        do_txn(1, 12'hFFF, 32'h0, 1'b0, 1'b1, lat, rd);
        checks++;
        if (lat !== 3 || rd !== model_read(12'hFFF, 1'b1)) begin
            errors++;
            $display("FAIL wrap_read: latency=%0d rdata=%h required 3 and %h", lat, rd, model_read(12'hFFF, 1'b1));
        end
        @(negedge clk);
    endtask

    task automatic requester_pair(input int r, input logic [11:0] a);
        int lat;
        logic [31:0] rd;
        for (int i = 0; i < 2; i++) begin
            do_txn(r, a, 32'h0, 1'b0, 1'b0, lat, rd);
            checks++;
            if (rd !== model_read(a, 1'b0)) begin
                errors++;
                $display("FAIL tie_read_%0d: rdata=%h required %h", r, rd, model_read(a, 1'b0));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_tie();
        grant_q.delete();
        fork
            requester_pair(0, 12'd20);
            requester_pair(1, 12'd30);
        join
        checks++;
        if (grant_q.size() != 4 || grant_q[0] != 0 || grant_q[1] != 1 || grant_q[2] != 0 || grant_q[3] != 1) begin
            errors++;
            $display("FAIL tie_order: %0d grants seen, required order 0,1,0,1", grant_q.size());
        end
        @(negedge clk);
    endtask

    task automatic test_holdoff();
        addr_0 = 12'd40; we_0 = 1'b0; dw_0 = 1'b1; req_0 = 1'b1;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            if (n == 1) begin addr_1 = 12'd41; we_1 = 1'b0; dw_1 = 1'b0; req_1 = 1'b1; end
            checks++;
            if (done_0 !== (n == 3) || done_1 !== (n == 6) || busy !== (n != 4)) begin
                errors++;
                $display("FAIL holdoff_cycle%0d: done_0=%b done_1=%b busy=%b required %b %b %b",
                         n, done_0, done_1, busy, n == 3, n == 6, n != 4);
            end
            if (done_0) begin
                checks++;
                if (rdata !== model_read(12'd40, 1'b1)) begin
                    errors++;
                    $display("FAIL holdoff_rdata0: rdata=%h required %h", rdata, model_read(12'd40, 1'b1));
                end
                req_0 = 1'b0;
            end
            if (done_1) begin
                checks++;
                if (rdata !== model_read(12'd41, 1'b0)) begin
                    errors++;
                    $display("FAIL holdoff_rdata1: rdata=%h required %h", rdata, model_read(12'd41, 1'b0));
                end
                req_1 = 1'b0;
            end
        end
        req_0 = 1'b0;
        req_1 = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_acc1();
        int lat;
        logic [31:0] rd, wd;
        wd = $urandom;
        addr_0 = 12'd50; wdata_0 = wd; we_0 = 1'b1; dw_0 = 1'b1; req_0 = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (mem !== 1'b0 || busy !== 1'b0 || done_0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_acc1: mem=%b busy=%b done_0=%b required 0 0 0", mem, busy, done_0);
        end
        req_0 = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (done_0 !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_abandon: done_0=%b busy=%b required 0 0", done_0, busy);
        end
        ref_mem[50] = wd[15:0];
        do_txn(0, 12'd50, wd, 1'b1, 1'b1, lat, rd);
        model_write(12'd50, wd, 1'b1);
        @(negedge clk);
        do_txn(0, 12'd50, 32'h0, 1'b0, 1'b1, lat, rd);
        checks++;
        if (lat !== 3 || rd !== model_read(12'd50, 1'b1)) begin
            errors++;
            $display("FAIL reset_retry: latency=%0d rdata=%h required 3 and %h", lat, rd, model_read(12'd50, 1'b1));
        end
        @(negedge clk);
    endtask

    task automatic test_input_change();
        int lat;
        lat = 0;
        addr_0 = 12'd200; wdata_0 = 32'h0000_012C; we_0 = 1'b1; dw_0 = 1'b0; req_0 = 1'b1;
        @(negedge clk);
        addr_0 = 12'd300;
        wdata_0 = 32'hDEAD_BEEF;
        while (done_0 !== 1'b1 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        req_0 = 1'b0;
        @(negedge clk);
        model_write(12'd200, 32'h0000_012C, 1'b0);
        checks++;
        if (mem_arr[200] !== 16'h012C || mem_arr[300] !== ref_mem[300]) begin
            errors++;
            $display("FAIL input_change: mem[200]=%h mem[300]=%h required 012C and %h",
                     mem_arr[200], mem_arr[300], ref_mem[300]);
        end
    endtask

    task automatic test_random();
        int lat, r;
        logic [11:0] a;
        logic [31:0] wd, rd;
        logic we, dw;
        for (int i = 0; i < 40; i++) begin
            r  = $urandom_range(0, 1);
            a  = ($urandom_range(0, 5) == 0) ? 12'hFFF : 12'($urandom_range(0, 63));
            wd = $urandom;
            we = 1'($urandom_range(0, 1));
            dw = 1'($urandom_range(0, 1));
            do_txn(r, a, wd, we, dw, lat, rd);
            checks++;
            if (lat != (dw ? 3 : 2)) begin
                errors++;
                $display("FAIL random_latency[%0d]: latency=%0d required %0d", i, lat, dw ? 3 : 2);
            end
            if (we) begin
                model_write(a, wd, dw);
            end else begin
                checks++;
                if (rd !== model_read(a, dw)) begin
                    errors++;
                    $display("FAIL random_rdata[%0d]: addr=%h dw=%b rdata=%h required %h", i, a, dw, rd, model_read(a, dw));
                end
            end
            @(negedge clk);
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            mem_arr[i] = 16'($urandom);
            ref_mem[i] = mem_arr[i];
        end
        test_reset();
        test_single();
        test_wrap();
        test_tie();
        test_holdoff();
        test_reset_acc1();
        test_input_change();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
